// File: rtl/rf_pkg.sv
// Shared definitions for the register bank: default geometry and data/address types.
package rf_pkg;

   localparam int RF_ELEM_WIDTH = 32;
   localparam int RF_NUM_REGS   = 16;
   localparam int RF_AW         = $clog2(RF_NUM_REGS);

   typedef logic [RF_AW-1:0]         rf_addr_t;
   typedef logic [RF_ELEM_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: selects zero / forwarded write data / stored data,
// then captures it with a one-cycle latency and a matching valid strobe.
module rf_read_port #(
   parameter int ELEM_WIDTH = 32,
   parameter int AW         = 4,
   parameter bit ZERO_REG   = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_rd_en,
   input  logic [AW-1:0]         i_raddr,
   input  logic                  i_addr_ok,
   input  logic [ELEM_WIDTH-1:0] i_mem_data,
   input  logic                  i_fwd_valid,
   input  logic [AW-1:0]         i_fwd_addr,
   input  logic [ELEM_WIDTH-1:0] i_fwd_data,
   output logic [ELEM_WIDTH-1:0] o_rdata,
   output logic                  o_rvalid
);

   logic [ELEM_WIDTH-1:0] w_rdata;
   logic [ELEM_WIDTH-1:0] r_rdata;
   logic                  r_rvalid;

   // Read value priority: out-of-range, then hardwired zero, then same-cycle write, then storage.
   always_comb begin
      w_rdata = i_mem_data;
      if (!i_addr_ok) begin
         w_rdata = '0;
      end else if (ZERO_REG && (i_raddr == '0)) begin
         w_rdata = '0;
      end else if (i_fwd_valid && (i_fwd_addr == i_raddr)) begin
         w_rdata = i_fwd_data;
      end
   end

   // Output register: data only moves on a request, valid follows the request.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= i_rd_en;
         if (i_rd_en) begin
            r_rdata <= w_rdata;
         end
      end
   end

   assign o_rdata  = r_rdata;
   assign o_rvalid = r_rvalid;

endmodule

// File: rtl/register_file.sv
// Multi-entry register bank: one write port, two registered read ports with
// write-to-read forwarding, and a one-cycle error pulse for out-of-range addresses.
module register_file
   import rf_pkg::*;
#(
   parameter int                    ELEM_WIDTH  = RF_ELEM_WIDTH,
   parameter int                    NUM_REGS    = RF_NUM_REGS,
   parameter logic [ELEM_WIDTH-1:0] RESET_VALUE = '0,
   parameter bit                    ZERO_REG    = 1'b1,
   localparam int                   AW          = $clog2(NUM_REGS)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [ELEM_WIDTH-1:0] wdata_i,
   input  logic                  rd0_en_i,
   input  logic [AW-1:0]         raddr0_i,
   output logic [ELEM_WIDTH-1:0] rdata0_o,
   output logic                  rvalid0_o,
   input  logic                  rd1_en_i,
   input  logic [AW-1:0]         raddr1_i,
   output logic [ELEM_WIDTH-1:0] rdata1_o,
   output logic                  rvalid1_o,
   output logic                  err_o
);

   logic [ELEM_WIDTH-1:0] r_mem [NUM_REGS];
   logic                  w_waddr_ok;
   logic                  w_raddr0_ok;
   logic                  w_raddr1_ok;
   logic                  w_wr_valid;
   logic [ELEM_WIDTH-1:0] w_mem_rd0;
   logic [ELEM_WIDTH-1:0] w_mem_rd1;

   // A fully populated address space has no illegal addresses, so the error path disappears.
   if (NUM_REGS == (1 << AW)) begin : g_full
      assign w_waddr_ok  = 1'b1;
      assign w_raddr0_ok = 1'b1;
      assign w_raddr1_ok = 1'b1;
      assign err_o       = 1'b0;
   end else begin : g_part
      logic r_err;

      assign w_waddr_ok  = (int'(waddr_i)  < NUM_REGS);
      assign w_raddr0_ok = (int'(raddr0_i) < NUM_REGS);
      assign w_raddr1_ok = (int'(raddr1_i) < NUM_REGS);

      // Error pulse: any range violation this cycle shows up for exactly one cycle.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_err <= 1'b0;
         end else begin
            r_err <= (we_i && !w_waddr_ok) || (rd0_en_i && !w_raddr0_ok) ||
                     (rd1_en_i && !w_raddr1_ok);
         end
      end

      assign err_o = r_err;
   end

   assign w_wr_valid = we_i && w_waddr_ok && !(ZERO_REG && (waddr_i == '0));

   // Storage: reset loads every entry, otherwise only legal writes land.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= RESET_VALUE;
         end
      end else if (w_wr_valid) begin
         r_mem[waddr_i] <= wdata_i;
      end
   end

   assign w_mem_rd0 = w_raddr0_ok ? r_mem[raddr0_i] : '0;
   assign w_mem_rd1 = w_raddr1_ok ? r_mem[raddr1_i] : '0;

   rf_read_port #(
      .ELEM_WIDTH (ELEM_WIDTH),
      .AW         (AW),
      .ZERO_REG   (ZERO_REG)
   ) u_rd0 (
      .i_clk       (clk_i),
      .i_rst       (rst_i),
      .i_rd_en     (rd0_en_i),
      .i_raddr     (raddr0_i),
      .i_addr_ok   (w_raddr0_ok),
      .i_mem_data  (w_mem_rd0),
      .i_fwd_valid (w_wr_valid),
      .i_fwd_addr  (waddr_i),
      .i_fwd_data  (wdata_i),
      .o_rdata     (rdata0_o),
      .o_rvalid    (rvalid0_o)
   );

   rf_read_port #(
      .ELEM_WIDTH (ELEM_WIDTH),
      .AW         (AW),
      .ZERO_REG   (ZERO_REG)
   ) u_rd1 (
      .i_clk       (clk_i),
      .i_rst       (rst_i),
      .i_rd_en     (rd1_en_i),
      .i_raddr     (raddr1_i),
      .i_addr_ok   (w_raddr1_ok),
      .i_mem_data  (w_mem_rd1),
      .i_fwd_valid (w_wr_valid),
      .i_fwd_addr  (waddr_i),
      .i_fwd_data  (wdata_i),
      .o_rdata     (rdata1_o),
      .o_rvalid    (rvalid1_o)
   );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a 16-entry and a 12-entry instance share one stimulus stream;
// a reference model predicts each cycle's outputs into a queue that is drained after the edge.
module tb_register_file;

   localparam logic [31:0] RV_A = 32'hA5A5_0000;
   localparam logic [31:0] RV_B = 32'h0BAD_F00D;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, we, rd0_en, rd1_en;
   logic [3:0]  waddr, raddr0, raddr1;
   logic [31:0] wdata;

   logic [31:0] a_rdata0, a_rdata1, b_rdata0, b_rdata1;
   logic        a_rvalid0, a_rvalid1, b_rvalid0, b_rvalid1, a_err, b_err;

   register_file #(.ELEM_WIDTH(32), .NUM_REGS(16), .RESET_VALUE(RV_A), .ZERO_REG(1'b1)) dut_a (
      .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .rd0_en_i(rd0_en), .raddr0_i(raddr0), .rdata0_o(a_rdata0), .rvalid0_o(a_rvalid0),
      .rd1_en_i(rd1_en), .raddr1_i(raddr1), .rdata1_o(a_rdata1), .rvalid1_o(a_rvalid1),
      .err_o(a_err)
   );

   register_file #(.ELEM_WIDTH(32), .NUM_REGS(12), .RESET_VALUE(RV_B), .ZERO_REG(1'b1)) dut_b (
      .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .rd0_en_i(rd0_en), .raddr0_i(raddr0), .rdata0_o(b_rdata0), .rvalid0_o(b_rvalid0),
      .rd1_en_i(rd1_en), .raddr1_i(raddr1), .rdata1_o(b_rdata1), .rvalid1_o(b_rvalid1),
      .err_o(b_err)
   );

   typedef struct packed {
      logic        v0;
      logic [31:0] d0;
      logic        v1;
      logic [31:0] d1;
      logic        err;
   } exp_t;

   exp_t        q_a[$];
   exp_t        q_b[$];
   logic [31:0] m_mem [2][16];
   logic [31:0] m_rd0 [2];
   logic [31:0] m_rd1 [2];
   int          n_cmp = 0;
   int          n_mis = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [31:0] model_read(int i, int n, logic wok, logic [3:0] ra);
      if (int'(ra) >= n) return 32'h0;
      if (ra == 4'd0) return 32'h0;
      if (wok && waddr == ra) return wdata;
      return m_mem[i][ra];
   endfunction

   // Predicts the outputs seen after the coming edge and advances the model state.
   function automatic exp_t model_step(int i);
      exp_t        e;
      int          n  = (i == 0) ? 16 : 12;
      logic [31:0] rv = (i == 0) ? RV_A : RV_B;
      logic        wok;
      e = '0;
      if (rst) begin
         for (int k = 0; k < 16; k++) m_mem[i][k] = rv;
         m_rd0[i] = 32'h0;
         m_rd1[i] = 32'h0;
      end else begin
         wok = we && (int'(waddr) < n) && (waddr != 4'd0);
         e.err = (we && int'(waddr) >= n) || (rd0_en && int'(raddr0) >= n) ||
                 (rd1_en && int'(raddr1) >= n);
         if (rd0_en) m_rd0[i] = model_read(i, n, wok, raddr0);
         if (rd1_en) m_rd1[i] = model_read(i, n, wok, raddr1);
         if (wok) m_mem[i][waddr] = wdata;
         e.v0 = rd0_en;
         e.v1 = rd1_en;
      end
      e.d0 = m_rd0[i];
      e.d1 = m_rd1[i];
      return e;
   endfunction

   task automatic cycle();
      exp_t e;
      q_a.push_back(model_step(0));
      q_b.push_back(model_step(1));
      @(posedge clk);
      #1;
      e = q_a.pop_front();
      chk("a_rvalid0", {31'b0, a_rvalid0}, {31'b0, e.v0});
      chk("a_rdata0",  a_rdata0,           e.d0);
      chk("a_rvalid1", {31'b0, a_rvalid1}, {31'b0, e.v1});
      chk("a_rdata1",  a_rdata1,           e.d1);
      chk("a_err",     {31'b0, a_err},     {31'b0, e.err});
      e = q_b.pop_front();
      chk("b_rvalid0", {31'b0, b_rvalid0}, {31'b0, e.v0});
      chk("b_rdata0",  b_rdata0,           e.d0);
      chk("b_rvalid1", {31'b0, b_rvalid1}, {31'b0, e.v1});
      chk("b_rdata1",  b_rdata1,           e.d1);
      chk("b_err",     {31'b0, b_err},     {31'b0, e.err});
   endtask

   task automatic idle();
      we = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0;
      waddr = 4'd0; raddr0 = 4'd0; raddr1 = 4'd0; wdata = 32'h0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      // reset, with a write and read presented that must be dropped
      we = 1'b1; waddr = 4'd2; wdata = 32'h1111_1111; rd0_en = 1'b1; raddr0 = 4'd2;
      cycle();
      chk("rst_rvalid0", {31'b0, a_rvalid0}, 32'h0);
      idle();
      cycle();
      rst = 1'b0;

      // reset contents on both ports of both instances
      for (int a = 0; a < 16; a++) begin
         rd0_en = 1'b1; raddr0 = 4'(a);
         rd1_en = 1'b1; raddr1 = 4'(15 - a);
         cycle();
         chk("t1_a_rdata0", a_rdata0, (a == 0) ? 32'h0 : RV_A);
      end

      // basic write then read
      idle(); we = 1'b1; waddr = 4'd3; wdata = 32'hDEAD_BEEF;
      cycle();
      idle(); rd0_en = 1'b1; raddr0 = 4'd3;
      cycle();
      chk("t2_rdata0", a_rdata0, 32'hDEAD_BEEF);
      chk("t2_rvalid0", {31'b0, a_rvalid0}, 32'h1);

      // forwarding on both ports
      idle(); we = 1'b1; waddr = 4'd5; wdata = 32'h1234_5678;
      rd0_en = 1'b1; raddr0 = 4'd5; rd1_en = 1'b1; raddr1 = 4'd5;
      cycle();
      chk("t3_a_rdata0", a_rdata0, 32'h1234_5678);
      chk("t3_a_rdata1", a_rdata1, 32'h1234_5678);
      chk("t3_b_rdata1", b_rdata1, 32'h1234_5678);

      // zero register
      idle(); we = 1'b1; waddr = 4'd0; wdata = 32'hFFFF_FFFF;
      cycle();
      idle(); rd0_en = 1'b1; raddr0 = 4'd0;
      cycle();
      chk("t4_rdata0", a_rdata0, 32'h0);
      chk("t4_err", {31'b0, b_err}, 32'h0);

      // out of range on the 12-entry instance, write and read
      idle(); we = 1'b1; waddr = 4'd14; wdata = 32'hCAFE_0001;
      cycle();
      chk("t5_werr", {31'b0, b_err}, 32'h1);
      idle(); rd0_en = 1'b1; raddr0 = 4'd14;
      cycle();
      chk("t5_b_rdata0", b_rdata0, 32'h0);
      chk("t5_rerr", {31'b0, b_err}, 32'h1);
      idle();
      cycle();
      chk("t5_err_drop", {31'b0, b_err}, 32'h0);
      for (int a = 0; a < 12; a++) begin
         rd0_en = 1'b1; raddr0 = 4'(a);
         cycle();
      end

      // random traffic with a reset in the middle
      for (int c = 0; c < 1000; c++) begin
         rst    = (c >= 500 && c < 502);
         we     = 1'($urandom_range(0, 1));
         waddr  = 4'($urandom_range(0, 15));
         wdata  = $urandom;
         rd0_en = 1'($urandom_range(0, 1));
         raddr0 = 4'($urandom_range(0, 15));
         rd1_en = 1'($urandom_range(0, 1));
         raddr1 = 4'($urandom_range(0, 15));
         if (c == 502) begin
            we = 1'b0; rd0_en = 1'b1; raddr0 = 4'd7;
         end
         cycle();
         if (c == 502) begin
            chk("t6_a_post_rst", a_rdata0, RV_A);
            chk("t6_b_post_rst", b_rdata0, RV_B);
         end
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
